// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SYNC/LEN/payload/XOR-checksum frame parser with buffered valid/ready drain
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'h55,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 320
) (
    input  logic       clk_uart,
    input  logic       rst_n,
    input  logic       next_byte,
    input  logic [7:0] data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] E_LEN = 2'd0, E_CSUM = 2'd1, E_TMO = 2'd2, E_OVR = 2'd3;

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;

    state_t        state, state_d;
    logic [LW-1:0] len, idx, rd;
    logic [7:0]    acc;
    logic [TW-1:0] tcnt;
    logic [7:0]    mem [MAX_LEN];

    logic       ok_d, err_d;
    logic [1:0] code_d;
    logic       in_frame, tmo, hs, last;

    assign in_frame  = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    assign tmo       = in_frame && !next_byte && (tcnt == TMO_LAST);
    assign out_valid = (state == DRAIN);
    assign last      = (rd == len - LW'(1));
    assign out_last  = out_valid && last;
    assign out_data  = out_valid ? mem[rd[IW-1:0]] : 8'h00;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d = state;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code;
        case (state)
            IDLE: begin
                if (next_byte && data == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                if (next_byte) begin
                    if (data == 8'h00 || data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = E_LEN;
                        state_d = IDLE;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (next_byte && (idx + LW'(1) == len)) state_d = CSUM;
            end
            CSUM: begin
                if (next_byte) begin
                    if (data == acc) begin
                        ok_d    = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = E_CSUM;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // Bytes arriving while draining are lost; the drain itself is unaffected.
                if (next_byte) begin
                    err_d  = 1'b1;
                    code_d = E_OVR;
                end
                if (hs && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A byte arriving in the expiry cycle keeps tmo low, so the byte wins.
        if (tmo) begin
            err_d   = 1'b1;
            code_d  = E_TMO;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            err_code  <= code_d;
        end
    end

    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            len  <= '0;
            idx  <= '0;
            rd   <= '0;
            acc  <= 8'h00;
            tcnt <= '0;
        end else begin
            if (!in_frame || next_byte || tmo) tcnt <= '0;
            else                               tcnt <= tcnt + TW'(1);
            case (state)
                LEN: begin
                    if (next_byte) begin
                        len <= data[LW-1:0];
                        acc <= data;
                        idx <= '0;
                    end
                end
                PAYLOAD: begin
                    if (next_byte) begin
                        acc <= acc ^ data;
                        idx <= idx + LW'(1);
                    end
                end
                CSUM: rd <= '0;
                DRAIN: begin
                    if (hs) rd <= last ? '0 : rd + LW'(1);
                end
                default: begin
                    idx <= '0;
                    rd  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_uart) begin
        if (state == PAYLOAD && next_byte) mem[idx[IW-1:0]] <= data;
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
    logic       clk_uart = 1'b0;
    logic       rst_n = 1'b0;
    logic       next_byte = 1'b0;
    logic [7:0] data = 8'h00;
    logic       out_valid, out_ready, out_last, frame_ok, frame_err;
    logic [7:0] out_data;
    logic [1:0] err_code;

    uart_frame_parser dut (
        .clk_uart(clk_uart), .rst_n(rst_n), .next_byte(next_byte), .data(data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk_uart = ~clk_uart;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [2:0] code;   // 0..3 err_code, 4 frame_ok
        int         cyc;    // required detection cycle, -1 when not checked
    } evt_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_strobe = 0;
    logic [8:0] exp_q[$];
    evt_t       evt_q[$];
    logic       stall_prev = 1'b0;
    logic [8:0] prev_out = '0;

    always @(posedge clk_uart) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    always @(negedge clk_uart) begin
        if (rst_n) begin
            if (stall_prev) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data_last", int'({out_last, out_data}), int'(prev_out));
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", int'(out_data), 256);
                else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", int'(out_data), int'(e[7:0]));
                    chk("out_last", int'(out_last), int'(e[8]));
                end
            end
            if (frame_ok && frame_err) chk("ok_err_same_cycle", 1, 0);
            if (frame_ok || frame_err) begin
                int code;
                code = frame_ok ? 4 : int'(err_code);
                if (evt_q.size() == 0) chk("unexpected_event", code, 7);
                else begin
                    evt_t ev;
                    ev = evt_q.pop_front();
                    chk("event_code", code, int'(ev.code));
                    if (ev.cyc >= 0) chk("event_cycle", cyc, ev.cyc);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk_uart);
        next_byte = 1'b1;
        data      = b;
        @(negedge clk_uart);
        next_byte   = 1'b0;
        last_strobe = cyc;
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic expect_out(input bq_t p);
        foreach (p[i]) exp_q.push_back({(i == p.size() - 1), p[i]});
    endtask

    task automatic expect_evt(input logic [2:0] code, input int at);
        evt_t ev;
        ev.code = code;
        ev.cyc  = at;
        evt_q.push_back(ev);
    endtask

    task automatic wait_drain(input string n, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || evt_q.size() != 0) && k < budget) begin
            @(negedge clk_uart);
            k++;
        end
        chk({n, "_pending"}, exp_q.size() + evt_q.size(), 0);
        repeat (4) @(negedge clk_uart);
    endtask

    initial begin
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_frame_ok", int'(frame_ok), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_err_code", int'(err_code), 0);
        repeat (3) @(negedge clk_uart);
        rst_n = 1'b1;

        // good frame, then its bad-checksum twin, then a 1-byte frame
        expect_evt(3'd4, -1);
        expect_out('{8'h11, 8'h22, 8'h33});
        send_seq('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        wait_drain("t1", 50);
        expect_evt(3'd1, -1);
        send_seq('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
        wait_drain("t2a", 20);
        chk("t2_err_code_held", int'(err_code), 1);
        expect_evt(3'd4, -1);
        expect_out('{8'hAA});
        send_seq('{8'h55, 8'h01, 8'hAA, 8'hAB});
        wait_drain("t2b", 50);

        // length errors, then a good frame (csum 02^A0^0B = A9)
        expect_evt(3'd0, -1);
        send_seq('{8'h55, 8'h00});
        expect_evt(3'd0, -1);
        send_seq('{8'h55, 8'h11});
        expect_evt(3'd4, -1);
        expect_out('{8'hA0, 8'h0B});
        send_seq('{8'h55, 8'h02, 8'hA0, 8'h0B, 8'hA9});
        wait_drain("t3", 50);

        // inter-byte timeout
        send_seq('{8'h55, 8'h02, 8'h10});
        expect_evt(3'd2, last_strobe + 320);
        repeat (400) @(negedge clk_uart);
        wait_drain("t4", 10);
        chk("t4_err_code", int'(err_code), 2);

        // stalled drain with two overruns (csum 04^01^02^03^04 = 00)
        out_ready = 1'b0;
        expect_evt(3'd4, -1);
        expect_out('{8'h01, 8'h02, 8'h03, 8'h04});
        send_seq('{8'h55, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00});
        expect_evt(3'd3, -1);
        send(8'h55);
        repeat (300) @(negedge clk_uart);
        expect_evt(3'd3, -1);
        send(8'h77);
        repeat (1700) @(negedge clk_uart);
        chk("t5_valid_stalled", int'(out_valid), 1);
        chk("t5_data_held", int'(out_data), 8'h01);
        chk("t5_events_seen", evt_q.size(), 0);
        out_ready = 1'b1;
        wait_drain("t5", 50);

        // garbage then SYNC-valued payload (csum 01^55 = 54), reset mid-drain
        out_ready = 1'b0;
        expect_evt(3'd4, -1);
        send_seq('{8'h00, 8'hFF, 8'h12, 8'h55, 8'h01, 8'h55, 8'h54});
        repeat (3) @(negedge clk_uart);
        chk("t6_valid", int'(out_valid), 1);
        chk("t6_data", int'(out_data), 8'h55);
        chk("t6_last", int'(out_last), 1);
        chk("t6_events_seen", evt_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_err_code", int'(err_code), 0);
        repeat (2) @(negedge clk_uart);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        expect_evt(3'd4, -1);
        expect_out('{8'h01, 8'h02});
        send_seq('{8'h55, 8'h02, 8'h01, 8'h02, 8'h01});
        wait_drain("t6", 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
